// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Two-requester round-robin write arbiter in front of a 2**AW-entry x DW-bit
//   register file that has a single write path. Each requester holds REQ until
//   it sees a one-cycle GNT pulse. In that cycle the arbiter drives the
//   requester's one-hot register enable on WEN and its data on WDATA.
//
// Optional feature: define ARB_CONFLICT_CNT_EN to add the CONFLICT_CNT port.
//   This is a saturating 8-bit count of the edges at which both raw requests
//   were high. It clears only on RST.
//
// Ports
//   CLK           in   1        rising-edge clock
//   RST           in   1        asynchronous reset, active-high
//   REQ_A         in   1        requester A write request (level)
//   ADDR_A        in   AW       requester A target register
//   DATA_A        in   DW       requester A write data
//   GNT_A         out  1        grant pulse to A (write issued this cycle)
//   REQ_B         in   1        requester B write request (level)
//   ADDR_B        in   AW       requester B target register
//   DATA_B        in   DW       requester B write data
//   GNT_B         out  1        grant pulse to B
//   WEN           out  2**AW    one-hot register enable, zero when idle
//   WDATA         out  DW       shared write data
//   CONFLICT_CNT  out  8        contention counter (ARB_CONFLICT_CNT_EN only)
//   fsm_state     out  2        debug view of the arbiter state
//                               (0 idle, 1 grant A, 2 grant B)
//
// Handshake: a request is REQ high at a rising edge while the same
// requester's GNT is low. The matching GNT is high for exactly the following
// cycle. REQ is ignored while its own GNT is high, so a requester can drop REQ
// in the grant cycle without receiving a second grant.
module regfile_wr_arbiter #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_A,
    input  logic [AW-1:0]        ADDR_A,
    input  logic [DW-1:0]        DATA_A,
    output logic                 GNT_A,
    input  logic                 REQ_B,
    input  logic [AW-1:0]        ADDR_B,
    input  logic [DW-1:0]        DATA_B,
    output logic                 GNT_B,
    output logic [(1<<AW)-1:0]   WEN,
    output logic [DW-1:0]        WDATA,
`ifdef ARB_CONFLICT_CNT_EN
    output logic [7:0]           CONFLICT_CNT,
`endif
    output logic [1:0]           fsm_state
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_A_ST = 2'd1,
        GNT_B_ST = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_a;      // 1: A won the most recent grant, 0: B (reset value)
    logic   elig_a;
    logic   elig_b;

    // Grants come straight from the state flops, so they are registered.
    assign GNT_A     = (state == GNT_A_ST);
    assign GNT_B     = (state == GNT_B_ST);
    assign fsm_state = state;

    always_comb begin
        elig_a     = REQ_A & ~GNT_A;
        elig_b     = REQ_B & ~GNT_B;
        state_next = IDLE;
        if (elig_a && !elig_b) begin
            state_next = GNT_A_ST;
        end else if (elig_b && !elig_a) begin
            state_next = GNT_B_ST;
        end else if (elig_a && elig_b) begin
            // Round robin: the side that did not win last time goes first.
            state_next = last_a ? GNT_B_ST : GNT_A_ST;
        end
    end

    // WEN/WDATA/last are captured at the same edge that enters the grant
    // state, so ADDR/DATA are sampled at the request edge. WDATA holds
    // through idle cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            WEN    <= '0;
            WDATA  <= '0;
            last_a <= 1'b0;
        end else begin
            state <= state_next;
            case (state_next)
                GNT_A_ST: begin
                    WEN    <= NREG'(1) << ADDR_A;
                    WDATA  <= DATA_A;
                    last_a <= 1'b1;
                end
                GNT_B_ST: begin
                    WEN    <= NREG'(1) << ADDR_B;
                    WDATA  <= DATA_B;
                    last_a <= 1'b0;
                end
                default: begin
                    WEN <= '0;
                end
            endcase
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    // Counts raw overlap (unmasked REQs) and saturates at 255.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CONFLICT_CNT <= 8'd0;
        end else if (REQ_A && REQ_B && (CONFLICT_CNT != 8'hFF)) begin
            CONFLICT_CNT <= CONFLICT_CNT + 8'd1;
        end
    end
`endif

endmodule
